// File: rtl/neat_pkg.sv
// Shared constants for the NEAT genome datapath: gene field layout, cfg word layout
// and the aligner FSM encoding.
package neat_pkg;

    localparam int DEF_GENE_SZ = 64;
    localparam int DEF_ATTR_SZ = 8;
    localparam int DEF_KEY_SZ  = 16;
    localparam int DEF_CNT_SZ  = 16;

    // Gene layout: {attr[63:56], key[55:40] (bit 55 = gene type), payload[39:0]}
    localparam int KEY_MSB  = DEF_GENE_SZ - DEF_ATTR_SZ - 1;
    localparam int KEY_LSB  = KEY_MSB - DEF_KEY_SZ + 1;
    localparam int TYPE_BIT = KEY_MSB;

    localparam int FIT_SZ     = 8;
    localparam int P1_FIT_MSB = 63;
    localparam int P2_FIT_MSB = 55;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

endpackage

// File: rtl/gene_pair_aligner_if.sv
// Parent gene streams in, gene-pair / setup bus out towards crossover_perturb.
interface gene_pair_aligner_if #(
    parameter int GENE_SZ = neat_pkg::DEF_GENE_SZ
);
    logic               p1_valid;
    logic [GENE_SZ-1:0] p1_gene;
    logic               p1_last;
    logic               p1_ready;
    logic               p2_valid;
    logic [GENE_SZ-1:0] p2_gene;
    logic               p2_last;
    logic               p2_ready;
    logic               setup;
    logic [GENE_SZ-1:0] data_out1;
    logic [GENE_SZ-1:0] data_out2;
    logic               pair_valid;

    modport master (
        output p1_valid, p1_gene, p1_last,
        output p2_valid, p2_gene, p2_last,
        input  p1_ready, p2_ready,
        input  setup, data_out1, data_out2, pair_valid
    );

    modport slave (
        input  p1_valid, p1_gene, p1_last,
        input  p2_valid, p2_gene, p2_last,
        output p1_ready, p2_ready,
        output setup, data_out1, data_out2, pair_valid
    );
endinterface

// File: rtl/gene_key_cmp.sv
// Extracts the innovation key from two genes and compares them (unsigned).
module gene_key_cmp
    import neat_pkg::*;
#(
    parameter int GENE_SZ = DEF_GENE_SZ,
    parameter int ATTR_SZ = DEF_ATTR_SZ,
    parameter int KEY_SZ  = DEF_KEY_SZ
) (
    input  logic [GENE_SZ-1:0] gene_a,
    input  logic [GENE_SZ-1:0] gene_b,
    output logic               eq,
    output logic               lt
);
    localparam int KMSB = GENE_SZ - ATTR_SZ - 1;
    localparam int KLSB = KMSB - KEY_SZ + 1;

    logic [KEY_SZ-1:0] key_a;
    logic [KEY_SZ-1:0] key_b;
    logic              unused_bits;

    assign key_a = gene_a[KMSB -: KEY_SZ];
    assign key_b = gene_b[KMSB -: KEY_SZ];

    // Attribute and payload fields play no part in alignment.
    assign unused_bits = ^{gene_a[GENE_SZ-1:KMSB+1], gene_a[KLSB-1:0],
                           gene_b[GENE_SZ-1:KMSB+1], gene_b[KLSB-1:0]};

    assign eq = (key_a == key_b);
    assign lt = (key_a < key_b);
endmodule

// File: rtl/gene_pair_aligner.sv
// Aligns two key-sorted parent gene streams into matched / fitter-parent pairs and
// drives the setup word on every non-pair cycle for crossover_perturb.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; output bus carries the setup word
//   ST_MERGE | popping heads, one pair decision per cycle until both ends
module gene_pair_aligner
    import neat_pkg::*;
#(
    parameter int GENE_SZ = DEF_GENE_SZ,
    parameter int ATTR_SZ = DEF_ATTR_SZ,
    parameter int KEY_SZ  = DEF_KEY_SZ,
    parameter int CNT_SZ  = DEF_CNT_SZ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [GENE_SZ-1:0] cfg_word,
    input  logic [ATTR_SZ-1:0] child_id,
    gene_pair_aligner_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic [CNT_SZ-1:0]  pair_count,
    output logic [CNT_SZ-1:0]  drop_count
);
    state_e             state_q, state_d;
    logic [GENE_SZ-1:0] cfg_q, cfg_d;
    logic [ATTR_SZ-1:0] child_q, child_d;
    logic               fit_sel_q, fit_sel_d;
    logic               end1_q, end1_d;
    logic               end2_q, end2_d;
    logic [CNT_SZ-1:0]  pair_cnt_q, pair_cnt_d;
    logic [CNT_SZ-1:0]  drop_cnt_q, drop_cnt_d;
    logic               setup_q, setup_d;
    logic [GENE_SZ-1:0] data1_q, data1_d;
    logic [GENE_SZ-1:0] data2_q, data2_d;
    logic               done_q, done_d;

    logic               key_eq, key_lt;
    logic               pop1, pop2, emit;
    logic [GENE_SZ-1:0] pair1, pair2;

    gene_key_cmp #(
        .GENE_SZ (GENE_SZ),
        .ATTR_SZ (ATTR_SZ),
        .KEY_SZ  (KEY_SZ)
    ) u_key_cmp (
        .gene_a (bus.p1_gene),
        .gene_b (bus.p2_gene),
        .eq     (key_eq),
        .lt     (key_lt)
    );

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        child_d    = child_q;
        fit_sel_d  = fit_sel_q;
        end1_d     = end1_q;
        end2_d     = end2_q;
        pair_cnt_d = pair_cnt_q;
        drop_cnt_d = drop_cnt_q;
        done_d     = 1'b0;
        pop1       = 1'b0;
        pop2       = 1'b0;
        emit       = 1'b0;
        pair1      = '0;
        pair2      = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_MERGE;
                    cfg_d      = cfg_word;
                    child_d    = child_id;
                    // Ties favour parent 1, same bias rule as downstream.
                    fit_sel_d  = cfg_word[P2_FIT_MSB -: FIT_SZ] > cfg_word[P1_FIT_MSB -: FIT_SZ];
                    end1_d     = 1'b0;
                    end2_d     = 1'b0;
                    pair_cnt_d = '0;
                    drop_cnt_d = '0;
                end
            end
            ST_MERGE: begin
                if (!end1_q && !end2_q) begin
                    if (bus.p1_valid && bus.p2_valid) begin
                        if (key_eq) begin
                            pop1  = 1'b1;
                            pop2  = 1'b1;
                            emit  = 1'b1;
                            pair1 = bus.p1_gene;
                            pair2 = bus.p2_gene;
                        end else if (key_lt) begin
                            pop1  = 1'b1;
                            emit  = !fit_sel_q;
                            pair1 = bus.p1_gene;
                            pair2 = bus.p1_gene;
                        end else begin
                            pop2  = 1'b1;
                            emit  = fit_sel_q;
                            pair1 = bus.p2_gene;
                            pair2 = bus.p2_gene;
                        end
                    end
                end else if (!end1_q) begin
                    if (bus.p1_valid) begin
                        pop1  = 1'b1;
                        emit  = !fit_sel_q;
                        pair1 = bus.p1_gene;
                        pair2 = bus.p1_gene;
                    end
                end else if (!end2_q) begin
                    if (bus.p2_valid) begin
                        pop2  = 1'b1;
                        emit  = fit_sel_q;
                        pair1 = bus.p2_gene;
                        pair2 = bus.p2_gene;
                    end
                end

                end1_d = end1_q | (pop1 & bus.p1_last);
                end2_d = end2_q | (pop2 & bus.p2_last);

                if (emit) begin
                    pair_cnt_d = (&pair_cnt_q) ? pair_cnt_q : pair_cnt_q + 1'b1;
                end else if (pop1 || pop2) begin
                    drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;
                end

                if (end1_d && end2_d) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Next-cycle config is used so the first setup word already carries it.
        if (emit) begin
            setup_d = 1'b0;
            data1_d = pair1;
            data2_d = pair2;
        end else begin
            setup_d = 1'b1;
            data1_d = cfg_d;
            data2_d = {{(GENE_SZ-ATTR_SZ){1'b0}}, child_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            child_q    <= '0;
            fit_sel_q  <= 1'b0;
            end1_q     <= 1'b0;
            end2_q     <= 1'b0;
            pair_cnt_q <= '0;
            drop_cnt_q <= '0;
            setup_q    <= 1'b1;
            data1_q    <= '0;
            data2_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            child_q    <= child_d;
            fit_sel_q  <= fit_sel_d;
            end1_q     <= end1_d;
            end2_q     <= end2_d;
            pair_cnt_q <= pair_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            setup_q    <= setup_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            done_q     <= done_d;
        end
    end

    assign bus.p1_ready   = pop1;
    assign bus.p2_ready   = pop2;
    assign bus.setup      = setup_q;
    assign bus.pair_valid = ~setup_q;
    assign bus.data_out1  = data1_q;
    assign bus.data_out2  = data2_q;
    assign busy           = (state_q == ST_MERGE);
    assign done           = done_q;
    assign pair_count     = pair_cnt_q;
    assign drop_count     = drop_cnt_q;
endmodule
